mod_seq_checker: RTL and testbench

//   Receive-side checker for the modulo-N up-counter stream. That stream emits
//   0 after reset, then 1..N, then wraps to 1. Each accepted sample must be the

---
 rtl/mod_seq_checker.sv | 124 ++++++++++++
 tb/tb_mod_seq_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mod_seq_checker.sv
// Receive-side checker for a modulo-N up-counter stream (0, 1..N, 1..N, ...).
// Flags illegal successors, counts errors (saturating) and legal N->1 wraps.
module mod_seq_checker #(
  parameter int W           = 11,
  parameter int MOD_DEFAULT = 200,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mod,
  input  logic [W-1:0]      mod_in,
  input  logic              in_valid,
  input  logic [W-1:0]      in_value,
  output logic              in_ready,
  input  logic              err_clr,
  output logic [W-1:0]      expected,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_SYNC  = 2'b00,
    S_TRACK = 2'b01,
    S_ERROR = 2'b10
  } st_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  st_t               st_q, st_d;
  logic [W-1:0]      mod_q, mod_d;
  logic [W-1:0]      prev_q, prev_d;
  logic [W-1:0]      exp_d;
  logic [ERR_W-1:0]  ec_d;
  logic [WRAP_W-1:0] wc_d;
  logic              bad, wp_d;
  logic              accept;
  logic [W-1:0]      succ_prev, succ_in;

  assign in_ready = !load_mod;
  assign accept   = in_valid & in_ready;
  assign locked   = (st_q == S_TRACK);
  assign state    = st_q;

  // mod never exceeds 2^W-1 and neither does p, so p+1 only runs when p<mod
  assign succ_prev = (prev_q == mod_q)   ? W'(1) : prev_q + W'(1);
  assign succ_in   = (in_value == mod_q) ? W'(1) : in_value + W'(1);

  always_comb begin
    st_d   = st_q;
    mod_d  = mod_q;
    prev_d = prev_q;
    exp_d  = expected;
    wc_d   = wrap_count;
    bad    = 1'b0;
    wp_d   = 1'b0;
    if (load_mod && (mod_in != '0)) begin
      mod_d  = mod_in;
      st_d   = S_SYNC;
      prev_d = '0;
      exp_d  = '0;
    end else if (accept) begin
      unique case (st_q)
        S_TRACK: begin
          if (in_value == succ_prev) begin
            prev_d = in_value;
            exp_d  = succ_in;
            if (prev_q == mod_q) begin
              wp_d = 1'b1;
              wc_d = wrap_count + WRAP_W'(1);
            end
          end else begin
            bad   = 1'b1;
            st_d  = S_ERROR;
            exp_d = '0;
          end
        end
        default: begin
          if (in_value <= mod_q) begin
            prev_d = in_value;
            st_d   = S_TRACK;
            exp_d  = succ_in;
          end else begin
            bad = 1'b1;
          end
        end
      endcase
    end
    // a clear coinciding with a fresh error still records that error
    if (err_clr)
      ec_d = bad ? ERR_W'(1) : '0;
    else if (bad && (err_count != ERR_MAX))
      ec_d = err_count + ERR_W'(1);
    else
      ec_d = err_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= S_SYNC;
      mod_q      <= W'(MOD_DEFAULT);
      prev_q     <= '0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      st_q       <= st_d;
      mod_q      <= mod_d;
      prev_q     <= prev_d;
      expected   <= exp_d;
      err_pulse  <= bad;
      wrap_pulse <= wp_d;
      err_count  <= ec_d;
      wrap_count <= wc_d;
    end
  end

endmodule

// File: tb/tb_mod_seq_checker.sv
// Bench for mod_seq_checker: vector table plus hand sequences,
// expected outputs queued at drive time and popped after the edge.
module tb_mod_seq_checker;

  typedef struct packed {
    logic [10:0] ex;
    logic        lk;
    logic        ep;
    logic        wp;
    logic [7:0]  ec;
    logic [15:0] wc;
    logic [1:0]  st;
  } out_t;

  typedef struct packed {
    logic        ld;
    logic [10:0] mi;
    logic        vld;
    logic [10:0] v;
    logic        clr;
    logic        rdy;
    out_t        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_mod = 1'b0;
  logic [10:0] mod_in = '0;
  logic        in_valid = 1'b0;
  logic [10:0] in_value = '0;
  logic        in_ready;
  logic        err_clr = 1'b0;
  logic [10:0] expected;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        wrap_pulse;
  logic [15:0] wrap_count;
  logic [1:0]  state;

  int checks = 0;
  int passes = 0;
  out_t  sbq[$];
  string nmq[$];
  vec_t  tbl[$];

  mod_seq_checker dut (
    .clk(clk), .rst(rst), .load_mod(load_mod), .mod_in(mod_in),
    .in_valid(in_valid), .in_value(in_value), .in_ready(in_ready),
    .err_clr(err_clr), .expected(expected), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  function automatic out_t mko(int ex, int lk, int ep, int wp,
                               int ec, int wc, int st);
    out_t o;
    o.ex = 11'(ex); o.lk = 1'(lk); o.ep = 1'(ep); o.wp = 1'(wp);
    o.ec = 8'(ec); o.wc = 16'(wc); o.st = 2'(st);
    return o;
  endfunction

  function automatic vec_t mk(int ld, int mi, int vld, int v, int clr,
                              int rdy, int ex, int lk, int ep, int wp,
                              int ec, int wc, int st);
    vec_t t;
    t.ld = 1'(ld); t.mi = 11'(mi); t.vld = 1'(vld); t.v = 11'(v);
    t.clr = 1'(clr); t.rdy = 1'(rdy);
    t.o = mko(ex, lk, ep, wp, ec, wc, st);
    return t;
  endfunction

  function automatic out_t act();
    out_t o;
    o.ex = expected; o.lk = locked; o.ep = err_pulse; o.wp = wrap_pulse;
    o.ec = err_count; o.wc = wrap_count; o.st = state;
    return o;
  endfunction

  task automatic cmp(input string nm, input out_t a, input out_t e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got ex=%0d lk=%0b ep=%0b wp=%0b ec=%0d wc=%0d st=%0d want ex=%0d lk=%0b ep=%0b wp=%0b ec=%0d wc=%0d st=%0d",
                  nm, a.ex, a.lk, a.ep, a.wp, a.ec, a.wc, a.st,
                  e.ex, e.lk, e.ep, e.wp, e.ec, e.wc, e.st);
  endtask

  task automatic cmp_rdy(input string nm, input logic a, input logic e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s in_ready: got %b want %b", nm, a, e);
  endtask

  task automatic step(input vec_t t, input string nm);
    out_t e;
    string n;
    @(negedge clk);
    load_mod = t.ld; mod_in = t.mi; in_valid = t.vld;
    in_value = t.v; err_clr = t.clr;
    #1;
    cmp_rdy(nm, in_ready, t.rdy);
    sbq.push_back(t.o);
    nmq.push_back(nm);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    n = nmq.pop_front();
    cmp(n, act(), e);
    load_mod = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    // T2: prev=5 then skip to 7; illegal resync attempt; recover on 8
    tbl.push_back(mk(1,200,0,0,0,0,   0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,1,5,0,1,     6,1,0,0,0,1,1));
    tbl.push_back(mk(0,0,1,7,0,1,     0,0,1,0,1,1,2));
    tbl.push_back(mk(0,0,0,0,0,1,     0,0,0,0,1,1,2));
    tbl.push_back(mk(0,0,1,250,0,1,   0,0,1,0,2,1,2));
    tbl.push_back(mk(0,0,1,8,0,1,     9,1,0,0,2,1,1));
    tbl.push_back(mk(0,0,1,9,0,1,     10,1,0,0,2,1,1));
    // T3: load mod=3 drops simultaneous sample; 1,2,3,1 wraps; 4 errs
    tbl.push_back(mk(1,3,1,9,0,0,     0,0,0,0,2,1,0));
    tbl.push_back(mk(0,0,1,1,0,1,     2,1,0,0,2,1,1));
    tbl.push_back(mk(0,0,1,2,0,1,     3,1,0,0,2,1,1));
    tbl.push_back(mk(0,0,1,3,0,1,     1,1,0,0,2,1,1));
    tbl.push_back(mk(0,0,1,1,0,1,     2,1,0,1,2,2,1));
    tbl.push_back(mk(0,0,1,4,0,1,     0,0,1,0,3,2,2));
    // T4: mod_in=0 ignored (mod stays 3); then mod=200, 201 errs in SYNC
    tbl.push_back(mk(1,0,1,2,0,0,     0,0,0,0,3,2,2));
    tbl.push_back(mk(0,0,1,3,0,1,     1,1,0,0,3,2,1));
    tbl.push_back(mk(1,200,0,0,0,0,   0,0,0,0,3,2,0));
    tbl.push_back(mk(1,0,0,0,0,0,     0,0,0,0,3,2,0));
    tbl.push_back(mk(0,0,1,201,0,1,   0,0,1,0,4,2,0));
    tbl.push_back(mk(0,0,1,200,0,1,   1,1,0,0,4,2,1));
    tbl.push_back(mk(0,0,1,1,0,1,     2,1,0,1,4,3,1));
    tbl.push_back(mk(0,0,1,2,0,1,     3,1,0,0,4,3,1));

    // reset state, no clock edge yet
    #3;
    cmp("reset", act(), mko(0,0,0,0,0,0,0));
    cmp_rdy("reset", in_ready, 1'b1);
    load_mod = 1'b1;
    #1;
    cmp_rdy("reset ld", in_ready, 1'b0);
    load_mod = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // T1: 0,1..200,1,2
    step(mk(0,0,1,0,0,1, 1,1,0,0,0,0,1), "T1 first");
    for (int v = 1; v <= 200; v++)
      step(mk(0,0,1,v,0,1, (v == 200) ? 1 : v + 1,1,0,0,0,0,1), "T1 run");
    step(mk(0,0,1,1,0,1, 2,1,0,1,0,1,1), "T1 wrap");
    step(mk(0,0,1,2,0,1, 3,1,0,0,0,1,1), "T1 post");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("tbl[%0d]", i));

    // T5: saturate at 255, then clear with a coincident error
    step(mk(1,200,0,0,0,0, 0,0,0,0,4,3,0), "T5 load");
    for (int i = 0; i < 300; i++)
      step(mk(0,0,1,2047,0,1, 0,0,1,0,(5 + i > 255) ? 255 : 5 + i,3,0),
           "T5 sat");
    step(mk(0,0,1,2047,1,1, 0,0,1,0,1,3,0), "T5 clr+err");
    step(mk(0,0,0,0,1,1,    0,0,0,0,0,3,0), "T5 clr");
    step(mk(0,0,1,7,0,1,    8,1,0,0,0,3,1), "T5 sync");

    // T6: async reset mid-stream with an error pending
    step(mk(1,200,0,0,0,0, 0,0,0,0,0,3,0), "T6 load");
    step(mk(0,0,1,150,0,1, 151,1,0,0,0,3,1), "T6 prev150");
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 11'd3;
    #2;
    rst = 1'b0;
    #1;
    cmp("T6 async", act(), mko(0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    cmp("T6 held", act(), mko(0,0,0,0,0,0,0));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(mk(0,0,1,0,0,1, 1,1,0,0,0,0,1), "T6 restart");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
